// File: rtl/disp_pkg.sv
// Shared definitions for the display palette encoder.
// Holds the terrain codes, the palette index helpers for the two flag
// entries, and the reset-time default colour table.
package disp_pkg;

  // Terrain codes carried in the low bits of a display cell
  localparam int unsigned EMPTY      = 0;
  localparam int unsigned AIR        = 1;
  localparam int unsigned DIRT       = 2;
  localparam int unsigned GROUND     = 3;
  localparam int unsigned QUEEN      = 4;
  localparam int unsigned WALL       = 5;
  localparam int unsigned ERRORBLOCK = 6;
  localparam int unsigned TUNNEL     = 7;

  // Palette entry holding the sugar colour (directly after the terrain entries)
  function automatic int unsigned sugar_idx(input int unsigned terrain_w);
    return 32'd1 << terrain_w;
  endfunction

  // Palette entry holding the ant colour
  function automatic int unsigned ant_idx(input int unsigned terrain_w);
    return sugar_idx(terrain_w) + 32'd1;
  endfunction

  // Reset colour for palette entry idx; the 3/3 geometry reproduces the legacy table
  function automatic logic [31:0] default_colour(input int unsigned terrain_w,
                                                 input int unsigned col_w,
                                                 input int unsigned idx);
    logic [31:0] all_ones;
    all_ones = (col_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << col_w) - 32'd1);
    if (idx == sugar_idx(terrain_w)) begin
      return 32'd1;
    end
    if (idx == ant_idx(terrain_w)) begin
      return 32'd0;
    end
    if (terrain_w == 3 && col_w == 3) begin
      case (idx)
        GROUND:  return 32'd2;
        WALL:    return 32'd4;
        TUNNEL:  return 32'd4;
        default: return 32'd7;
      endcase
    end
    return all_ones;
  endfunction

endpackage

// File: rtl/disp_palette_rf.sv
// Palette register file: (2**TERRAIN_W + 2) entries of COL_W bits.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (reloads default colours)
//   we_i        write strobe; wr_addr_i/wr_data_i select entry and colour
//               (addresses past the last entry are dropped)
//   rd_en_i     read strobe; rd_addr_i selects the entry
//   rd_data_o   registered read data, holds when rd_en_i is low
// A read and a write to the same entry on one edge return the old colour.
module disp_palette_rf
  import disp_pkg::*;
#(
  parameter int unsigned TERRAIN_W = 3,
  parameter int unsigned COL_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [TERRAIN_W:0] wr_addr_i,
  input  logic [COL_W-1:0]   wr_data_i,
  input  logic               rd_en_i,
  input  logic [TERRAIN_W:0] rd_addr_i,
  output logic [COL_W-1:0]   rd_data_o
);

  localparam int unsigned NE = ant_idx(TERRAIN_W) + 1;

  logic [COL_W-1:0] mem_q [NE];
  logic [COL_W-1:0] mem_d [NE];
  logic [COL_W-1:0] rd_data_q;
  logic [COL_W-1:0] rd_data_d;
  logic             wr_hit_c;

  assign wr_hit_c = we_i && (32'(wr_addr_i) < NE);

  // Next-state: write merges into the array, read samples the pre-write contents
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (wr_hit_c) begin
      mem_d[wr_addr_i] = wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  // Storage and read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NE; i++) begin
        mem_q[i] <= COL_W'(default_colour(TERRAIN_W, COL_W, i));
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/disp_palette_encoder.sv
// Two-stage cell-to-colour encoder between display read-out and VGA driver.
// Stage 1 classifies a cell into a palette index (sugar > ant > terrain);
// stage 2 looks the index up in a run-time writable palette.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   disp_valid    disp carries a live pixel this cycle
//   disp          {sugar, ant, terrain[TERRAIN_W-1:0]}
//   frame_start   one-cycle pulse per frame (only used for ant blinking)
//   pal_we        palette write strobe, pal_addr/pal_data select entry/colour
//   col_valid     outCol carries a pixel (exactly 2 cycles after disp_valid)
//   outCol        encoded colour, holds between valid pixels
// Build option: define ANT_BLINK_EN to hide ant-only cells every other
// 2**BLINK_PERIOD_LOG2 frames.
module disp_palette_encoder
  import disp_pkg::*;
#(
  parameter int unsigned TERRAIN_W         = 3,
  parameter int unsigned COL_W             = 3,
  parameter int unsigned BLINK_PERIOD_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 disp_valid,
  input  logic [TERRAIN_W+1:0] disp,
  input  logic                 frame_start,
  input  logic                 pal_we,
  input  logic [TERRAIN_W:0]   pal_addr,
  input  logic [COL_W-1:0]     pal_data,
  output logic                 col_valid,
  output logic [COL_W-1:0]     outCol
);

  localparam int unsigned IDX_W       = TERRAIN_W + 1;
  localparam int unsigned BLINK_CNT_W = BLINK_PERIOD_LOG2 + 1;
  localparam logic [IDX_W-1:0] SUGAR_I = IDX_W'(sugar_idx(TERRAIN_W));
  localparam logic [IDX_W-1:0] ANT_I   = IDX_W'(ant_idx(TERRAIN_W));

  logic                 sugar_c;
  logic                 ant_c;
  logic [TERRAIN_W-1:0] terrain_c;
  logic                 ant_hide_c;
  logic [IDX_W-1:0]     idx_d;
  logic [IDX_W-1:0]     idx_q;
  logic                 s1_valid_q;
  logic                 col_valid_q;

  assign sugar_c   = disp[TERRAIN_W+1];
  assign ant_c     = disp[TERRAIN_W];
  assign terrain_c = disp[TERRAIN_W-1:0];

`ifdef ANT_BLINK_EN
  logic [BLINK_CNT_W-1:0] blink_cnt_q;
  logic [BLINK_CNT_W-1:0] blink_cnt_d;

  // Frame counter; its MSB marks the half-period in which ants are hidden
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (frame_start) begin
      blink_cnt_d = blink_cnt_q + BLINK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Registered count: a pulse alongside a pixel only affects later pixels
  assign ant_hide_c = blink_cnt_q[BLINK_CNT_W-1];
`else
  logic [BLINK_CNT_W-1:0] unused_blink_c;

  assign unused_blink_c = {BLINK_CNT_W{frame_start}};
  assign ant_hide_c     = 1'b0;
`endif

  // Stage-1 classification; a hidden ant falls through to its terrain
  always_comb begin
    idx_d = {1'b0, terrain_c};
    if (sugar_c) begin
      idx_d = SUGAR_I;
    end else if (ant_c && !ant_hide_c) begin
      idx_d = ANT_I;
    end
  end

  // Index and valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      col_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      s1_valid_q  <= disp_valid;
      col_valid_q <= s1_valid_q;
    end
  end

  // Stage-2 lookup; the read register doubles as the outCol register
  disp_palette_rf #(
    .TERRAIN_W (TERRAIN_W),
    .COL_W     (COL_W)
  ) u_palette_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (pal_we),
    .wr_addr_i (pal_addr),
    .wr_data_i (pal_data),
    .rd_en_i   (s1_valid_q),
    .rd_addr_i (idx_q),
    .rd_data_o (outCol)
  );

  assign col_valid = col_valid_q;

endmodule

// File: tb/tb_disp_palette_encoder.sv
// Directed bench for disp_palette_encoder (TERRAIN_W=3, COL_W=3, BLINK_PERIOD_LOG2=1).
// Expected colours are queued when a pixel is driven and popped when col_valid rises.
module tb_disp_palette_encoder;

  logic       clk;
  logic       rst_n;
  logic       disp_valid;
  logic [4:0] disp;
  logic       frame_start;
  logic       pal_we;
  logic [3:0] pal_addr;
  logic [2:0] pal_data;
  logic       col_valid;
  logic [2:0] outCol;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [2:0]  sb[$];
  logic        exp_s1_valid;
  logic [2:0]  last_col;

  disp_palette_encoder #(
    .TERRAIN_W         (3),
    .COL_W             (3),
    .BLINK_PERIOD_LOG2 (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_valid  (disp_valid),
    .disp        (disp),
    .frame_start (frame_start),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .col_valid   (col_valid),
    .outCol      (outCol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, then check outputs 1 time unit after the edge
  task automatic cyc(input logic v, input logic [4:0] d, input logic fs,
                     input logic we, input logic [3:0] a, input logic [2:0] wd);
    logic [2:0] e;
    disp_valid  = v;
    disp        = d;
    frame_start = fs;
    pal_we      = we;
    pal_addr    = a;
    pal_data    = wd;
    @(posedge clk);
    #1;
    chk("col_valid", 32'(col_valid), 32'(exp_s1_valid));
    if (exp_s1_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e = sb.pop_front();
        chk("outCol", 32'(outCol), 32'(e));
        last_col = e;
      end
    end else begin
      chk("outCol_hold", 32'(outCol), 32'(last_col));
    end
    exp_s1_valid = v;
  endtask

  task automatic pix(input logic [4:0] d, input logic [2:0] expc);
    sb.push_back(expc);
    cyc(1'b1, d, 1'b0, 1'b0, 4'd0, 3'd0);
  endtask

  task automatic pix_wr(input logic [4:0] d, input logic [2:0] expc,
                        input logic [3:0] a, input logic [2:0] wd);
    sb.push_back(expc);
    cyc(1'b1, d, 1'b0, 1'b1, a, wd);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 3'd0);
  endtask

  initial begin
    logic [2:0] t1_exp [8];
    logic [2:0] t3_exp [8];
    logic [2:0] blink_exp;
    n_tests      = 0;
    n_fail       = 0;
    exp_s1_valid = 1'b0;
    last_col     = 3'd0;
    rst_n        = 1'b0;
    disp_valid   = 1'b0;
    disp         = 5'd0;
    frame_start  = 1'b0;
    pal_we       = 1'b0;
    pal_addr     = 4'd0;
    pal_data     = 3'd0;
    t1_exp = '{3'd7, 3'd7, 3'd7, 3'd2, 3'd7, 3'd4, 3'd7, 3'd4};
    t3_exp = '{3'd7, 3'd7, 3'd7, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4};

    // Reset state
    #2;
    chk("rst_col_valid", 32'(col_valid), 32'd0);
    chk("rst_outCol", 32'(outCol), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Terrain 0..7, back to back
    for (int i = 0; i < 8; i++) begin
      pix(5'(i), t1_exp[i]);
    end
    idle();
    idle();

    // Flag priority
    pix(5'b11011, 3'd1);
    pix(5'b01011, 3'd0);
    pix(5'b10111, 3'd1);
    idle();
    idle();

    // Write to ground on the edge that reads ground: old colour, then new
    pix(5'd3, 3'd2);
    pix_wr(5'd3, 3'd5, 4'd3, 3'd5);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 4'd12, 3'd0);
    for (int i = 0; i < 8; i++) begin
      pix(5'(i), t3_exp[i]);
    end
    pix(5'b10000, 3'd1);
    pix(5'b01000, 3'd0);
    idle();
    idle();

    // Reset with pixels in flight after further writes
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 4'd8, 3'd6);
    pix(5'd3, 3'd5);
    pix(5'b10000, 3'd6);
    pix(5'd3, 3'd5);
    chk("pre_rst_col_valid", 32'(col_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_col_valid", 32'(col_valid), 32'd0);
    chk("midrst_outCol", 32'(outCol), 32'd0);
    sb.delete();
    exp_s1_valid = 1'b0;
    last_col     = 3'd0;
    disp_valid   = 1'b0;
    pal_we       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix(5'd3, 3'd2);
    pix(5'b10000, 3'd1);
    idle();
    idle();

    // Valid gaps 1,0,0,1: col_valid follows two cycles later, outCol holds
    pix(5'd3, 3'd2);
    idle();
    idle();
    pix(5'd5, 3'd4);
    idle();
    idle();
    idle();

    // Ant on tunnel across frames
    for (int f = 0; f < 6; f++) begin
`ifdef ANT_BLINK_EN
      blink_exp = (f == 2 || f == 3) ? 3'd4 : 3'd0;
`else
      blink_exp = 3'd0;
`endif
      pix(5'b01111, blink_exp);
      cyc(1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 3'd0);
    end
    idle();
    idle();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
